// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Bridges a single-outstanding CPU load/store port onto a 32-bit synchronous
// RAM (one cycle read latency). Handles byte/halfword/word sizes with
// little-endian lanes, sign/zero extension of loads, and read-modify-write
// for sub-word stores. Out-of-range word addresses are rejected with resp_err.
//
// Optional feature: define MISALIGN_CHECK_EN to reject misaligned halfword and
// word accesses. Without it, the low address bits are ignored (forced alignment).
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   req_valid / req_ready   request handshake (ready only in IDLE)
//   req_we, req_addr,       store flag, byte address,
//   req_size, req_signed,   size (00 B, 01 H, 1x W), sign-extend loads,
//   req_wdata               right-aligned store data
//   resp_valid              one-cycle completion pulse
//   resp_rdata, resp_err    extended load data (held), rejection flag
//   ram_wren, ram_address,  RAM write enable, word address,
//   ram_data, ram_q         write data, read data (one cycle after address)
module mem_access_ctrl #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        ram_wren,
    output logic [29:0] ram_address,
    output logic [31:0] ram_data,
    input  logic [31:0] ram_q
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RMW_WR, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] cap_addr;
    logic [1:0]  cap_size;
    logic        cap_signed;
    logic [15:0] cap_wdata;   // only sub-word stores use the captured data
    logic        cap_err;
    logic [31:0] rdata_q, rdata_d;

    logic        accept, req_word, req_half, req_oor, req_misalign, req_bad;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] load_ext, merged;

    // ---------------- request decode ----------------
    assign req_ready = rst_n && (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign req_word  = req_size[1];          // 11 behaves as word
    assign req_half  = (req_size == 2'b01);
    assign req_oor   = ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

`ifdef MISALIGN_CHECK_EN
    assign req_misalign = (req_half && req_addr[0]) ||
                          (req_word && (req_addr[1:0] != 2'b00));
`else
    assign req_misalign = 1'b0;
`endif

    assign req_bad = req_oor || req_misalign;

    // ---------------- load extraction (captured request, live ram_q) ----------------
    always_comb begin
        ld_b = ram_q[7:0];
        case (cap_addr[1:0])
            2'd0: ld_b = ram_q[7:0];
            2'd1: ld_b = ram_q[15:8];
            2'd2: ld_b = ram_q[23:16];
            2'd3: ld_b = ram_q[31:24];
            default: ld_b = ram_q[7:0];
        endcase
        ld_h = cap_addr[1] ? ram_q[31:16] : ram_q[15:0];
        case (cap_size)
            2'b00:   load_ext = {{24{cap_signed & ld_b[7]}}, ld_b};
            2'b01:   load_ext = {{16{cap_signed & ld_h[15]}}, ld_h};
            default: load_ext = ram_q;
        endcase
    end

    // ---------------- store merge for read-modify-write ----------------
    always_comb begin
        merged = ram_q;
        if (cap_size == 2'b00) begin
            case (cap_addr[1:0])
                2'd0: merged[7:0]   = cap_wdata[7:0];
                2'd1: merged[15:8]  = cap_wdata[7:0];
                2'd2: merged[23:16] = cap_wdata[7:0];
                2'd3: merged[31:24] = cap_wdata[7:0];
                default: merged = ram_q;
            endcase
        end else if (cap_addr[1]) begin
            merged[31:16] = cap_wdata;
        end else begin
            merged[15:0] = cap_wdata;
        end
    end

    // ---------------- next state / RAM outputs ----------------
    always_comb begin
        state_d     = state_q;
        ram_wren    = 1'b0;
        ram_address = cap_addr[31:2];
        ram_data    = merged;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                // Address is presented straight from the request so the RAM
                // read for loads/RMW starts in the accept cycle.
                ram_address = req_addr[31:2];
                ram_data    = req_wdata;
                if (accept) begin
                    if (req_bad) begin
                        state_d = RESP;
                        rdata_d = '0;
                    end else if (req_we && req_word) begin
                        ram_wren = 1'b1;
                        state_d  = RESP;
                        rdata_d  = '0;
                    end else if (req_we) begin
                        state_d = RMW_WR;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                rdata_d = load_ext;
                state_d = RESP;
            end
            RMW_WR: begin
                ram_wren = 1'b1;
                rdata_d  = '0;
                state_d  = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Reset must kill a write immediately, not just at the next edge.
        if (!rst_n) ram_wren = 1'b0;
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cap_addr   <= '0;
            cap_size   <= '0;
            cap_signed <= 1'b0;
            cap_wdata  <= '0;
            cap_err    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            if (accept) begin
                cap_addr   <= req_addr;
                cap_size   <= req_size;
                cap_signed <= req_signed;
                cap_wdata  <= req_wdata[15:0];
                cap_err    <= req_bad;
            end
        end
    end

    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_valid && cap_err;
    assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural 1024-word synchronous
// RAM. Inputs change on the falling edge; outputs are sampled 1 time unit
// after the falling edge.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        ram_wren;
    logic [29:0] ram_address;
    logic [31:0] ram_data;
    logic [31:0] ram_q;

    logic [31:0] mem [0:1023];
    int          wr_cnt = 0;
    int          resp_cnt = 0;
    int          errors = 0;
    int          checks = 0;

    // results of the last do_req
    logic        t_rdy, t_wren, d1_wren, er;
    logic [29:0] t_addr;
    logic [31:0] d1_data, rd;
    int          lat, nwr;

    always #5 clk = ~clk;

    mem_access_ctrl #(.MEM_WORDS(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_wren(ram_wren), .ram_address(ram_address), .ram_data(ram_data),
        .ram_q(ram_q)
    );

    always @(posedge clk) begin
        if (ram_wren) mem[ram_address[9:0]] <= ram_data;
        ram_q <= mem[ram_address[9:0]];
        if (ram_wren) wr_cnt <= wr_cnt + 1;
        if (resp_valid) resp_cnt <= resp_cnt + 1;
    end

    // Issue one request and follow it to its response (bounded at 10 cycles).
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic sgn, input logic [31:0] wd);
        int wr0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_signed = sgn; req_wdata = wd;
        #1;
        t_rdy = req_ready; t_wren = ram_wren; t_addr = ram_address;
        wr0 = wr_cnt;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0;
        #1;
        d1_wren = ram_wren; d1_data = ram_data;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(negedge clk); #1; lat++;
        end
        rd = resp_rdata; er = resp_err; nwr = wr_cnt - wr0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0; req_size = 2'b10;
        req_signed = 1'b0; req_wdata = 32'h12345678;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL rst_wren: got %b want 0", ram_wren); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", resp_valid); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", resp_err); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", resp_rdata); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", req_ready); end
        req_valid = 1'b0; req_we = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rel_ready: got %b want 1", req_ready); end
        checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL rst_nowrite: got %0d want 0", wr_cnt); end
    endtask

    task automatic test_word_store_load;
        do_req(1'b1, 32'h40, 2'b10, 1'b0, 32'hDEADBEEF);
        checks++; if (t_rdy !== 1'b1) begin errors++; $display("FAIL ws_ready: got %b want 1", t_rdy); end
        checks++; if (t_wren !== 1'b1) begin errors++; $display("FAIL ws_wren_T: got %b want 1", t_wren); end
        checks++; if (t_addr !== 30'h10) begin errors++; $display("FAIL ws_addr_T: got %h want 10", t_addr); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL ws_lat: got %0d want 1", lat); end
        checks++; if (nwr !== 1) begin errors++; $display("FAIL ws_nwr: got %0d want 1", nwr); end
        checks++; if ({er, rd} !== 33'h0) begin errors++; $display("FAIL ws_resp: got err=%b rd=%h want 0/0", er, rd); end
        do_req(1'b0, 32'h40, 2'b10, 1'b0, 32'h0);
        checks++; if (t_rdy !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", t_rdy); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL wl_lat: got %0d want 2", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL wl_rdata: got %h want deadbeef", rd); end
        checks++; if (nwr !== 0) begin errors++; $display("FAIL wl_nwr: got %0d want 0", nwr); end
        @(negedge clk); #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL wl_pulse: got %b want 0", resp_valid); end
        checks++; if (resp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wl_hold: got %h want deadbeef", resp_rdata); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL wl_ready_after: got %b want 1", req_ready); end
    endtask

    task automatic test_subword_store;
        do_req(1'b1, 32'h40, 2'b10, 1'b0, 32'h11223344);
        do_req(1'b1, 32'h42, 2'b00, 1'b0, 32'hFFFFFFAA);
        checks++; if (t_wren !== 1'b0) begin errors++; $display("FAIL sb_wren_T: got %b want 0", t_wren); end
        checks++; if (d1_wren !== 1'b1) begin errors++; $display("FAIL sb_wren_T1: got %b want 1", d1_wren); end
        checks++; if (d1_data !== 32'h11AA3344) begin errors++; $display("FAIL sb_data: got %h want 11aa3344", d1_data); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL sb_lat: got %0d want 2", lat); end
        checks++; if (nwr !== 1) begin errors++; $display("FAIL sb_nwr: got %0d want 1", nwr); end
        checks++; if ({er, rd} !== 33'h0) begin errors++; $display("FAIL sb_resp: got err=%b rd=%h want 0/0", er, rd); end
        do_req(1'b1, 32'h40, 2'b01, 1'b0, 32'h00005566);
        checks++; if (d1_data !== 32'h11AA5566) begin errors++; $display("FAIL sh_data: got %h want 11aa5566", d1_data); end
        do_req(1'b1, 32'h43, 2'b00, 1'b0, 32'h00000099);
        checks++; if (d1_data !== 32'h99AA5566) begin errors++; $display("FAIL sb3_data: got %h want 99aa5566", d1_data); end
        do_req(1'b0, 32'h40, 2'b10, 1'b0, 32'h0);
        checks++; if (rd !== 32'h99AA5566) begin errors++; $display("FAIL rmw_readback: got %h want 99aa5566", rd); end
    endtask

    task automatic test_load_extend;
        do_req(1'b1, 32'h0, 2'b10, 1'b0, 32'h0000F080);
        do_req(1'b0, 32'h0, 2'b00, 1'b1, 32'h0);
        checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_s: got %h want ffffff80", rd); end
        do_req(1'b0, 32'h0, 2'b01, 1'b0, 32'h0);
        checks++; if (rd !== 32'h0000F080) begin errors++; $display("FAIL lh_u: got %h want 0000f080", rd); end
        do_req(1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
        checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lb_u: got %h want 00000080", rd); end
        do_req(1'b0, 32'h0, 2'b01, 1'b1, 32'h0);
        checks++; if (rd !== 32'hFFFFF080) begin errors++; $display("FAIL lh_s: got %h want fffff080", rd); end
        do_req(1'b0, 32'h1, 2'b00, 1'b1, 32'h0);
        checks++; if (rd !== 32'hFFFFFFF0) begin errors++; $display("FAIL lb1_s: got %h want fffffff0", rd); end
        do_req(1'b0, 32'h2, 2'b01, 1'b1, 32'h0);
        checks++; if (rd !== 32'h00000000) begin errors++; $display("FAIL lh2_s: got %h want 0", rd); end
        do_req(1'b0, 32'h0, 2'b11, 1'b1, 32'h0);
        checks++; if (rd !== 32'h0000F080) begin errors++; $display("FAIL lsz3: got %h want 0000f080", rd); end
    endtask

    task automatic test_range;
        do_req(1'b0, 32'h1000, 2'b10, 1'b0, 32'h0);
        checks++; if (lat !== 1) begin errors++; $display("FAIL oor_lat: got %0d want 1", lat); end
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_err: got %b want 1", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_rdata: got %h want 0", rd); end
        checks++; if (nwr !== 0) begin errors++; $display("FAIL oor_nwr: got %0d want 0", nwr); end
        do_req(1'b1, 32'h1002, 2'b00, 1'b0, 32'h55);
        checks++; if ({er, nwr[3:0], lat[3:0]} !== 9'b1_0000_0001) begin errors++; $display("FAIL oor_st: got err=%b nwr=%0d lat=%0d want 1/0/1", er, nwr, lat); end
        do_req(1'b1, 32'hFFC, 2'b10, 1'b0, 32'hA5A5A5A5);
        checks++; if ({er, nwr[3:0]} !== 5'b0_0001) begin errors++; $display("FAIL top_word: got err=%b nwr=%0d want 0/1", er, nwr); end
        do_req(1'b0, 32'hFFC, 2'b10, 1'b0, 32'h0);
        checks++; if ({er, rd} !== {1'b0, 32'hA5A5A5A5}) begin errors++; $display("FAIL top_read: got err=%b rd=%h want 0/a5a5a5a5", er, rd); end
    endtask

    task automatic test_misalign;
        do_req(1'b1, 32'h40, 2'b10, 1'b0, 32'h0BADF00D);
        do_req(1'b1, 32'h42, 2'b10, 1'b0, 32'h12345678);
`ifdef MISALIGN_CHECK_EN
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL mis_err: got %b want 1", er); end
        checks++; if (nwr !== 0) begin errors++; $display("FAIL mis_nwr: got %0d want 0", nwr); end
        do_req(1'b0, 32'h40, 2'b10, 1'b0, 32'h0);
        checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL mis_mem: got %h want 0badf00d", rd); end
`else
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL mis_err: got %b want 0", er); end
        checks++; if ({t_wren, t_addr} !== {1'b1, 30'h10}) begin errors++; $display("FAIL mis_addr: got wren=%b addr=%h want 1/10", t_wren, t_addr); end
        do_req(1'b0, 32'h40, 2'b10, 1'b0, 32'h0);
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL mis_mem: got %h want 12345678", rd); end
`endif
    endtask

    task automatic test_reset_rmw;
        int wr0, r0;
        do_req(1'b1, 32'h80, 2'b10, 1'b0, 32'hCAFEF00D);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h81; req_size = 2'b00; req_wdata = 32'h11;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0;
        #1;
        checks++; if (ram_wren !== 1'b1) begin errors++; $display("FAIL rr_wren: got %b want 1", ram_wren); end
        checks++; if (ram_data !== 32'hCAFE110D) begin errors++; $display("FAIL rr_data: got %h want cafe110d", ram_data); end
        wr0 = wr_cnt; r0 = resp_cnt;
        rst_n = 1'b0;
        #1;
        checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL rr_wren_drop: got %b want 0", ram_wren); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rr_ready: got %b want 1", req_ready); end
        checks++; if (wr_cnt !== wr0) begin errors++; $display("FAIL rr_nowrite: got %0d want %0d", wr_cnt, wr0); end
        checks++; if (resp_cnt !== r0) begin errors++; $display("FAIL rr_noresp: got %0d want %0d", resp_cnt, r0); end
        do_req(1'b0, 32'h80, 2'b10, 1'b0, 32'h0);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL rr_mem: got %h want cafef00d", rd); end
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_subword_store();
        test_load_extend();
        test_range();
        test_misalign();
        test_reset_rmw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 1024, meaning number of 32-bit words in the attached RAM.
REQ-002 The block SHALL have port clk, input, 1, system clock with all logic on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port req_valid, input, 1, meaning CPU request present.
REQ-005 The block SHALL have port req_ready, output, 1, meaning the block accepts a request this cycle.
REQ-006 The block SHALL have port req_we, input, 1, meaning 1=store, 0=load.
REQ-007 The block SHALL have port req_addr, input, 32, meaning byte address.
REQ-008 The block SHALL have port req_size, input, 2, meaning 00 byte, 01 halfword, 10 word (11 SHALL be treated as word).
REQ-009 The block SHALL have port req_signed, input, 1, meaning sign-extend load result.
REQ-010 The block SHALL have port req_wdata, input, 32, meaning store data, right-aligned.
REQ-011 The block SHALL have port resp_valid, output, 1, meaning a one-cycle completion pulse.
REQ-012 The block SHALL have port resp_rdata, output, 32, meaning load result, extended.
REQ-013 The block SHALL have port resp_err, output, 1, meaning the request was rejected; valid with resp_valid.
REQ-014 The block SHALL have port ram_wren, output, 1, meaning RAM write enable.
REQ-015 The block SHALL have port ram_address, output, 30, meaning RAM word address.
REQ-016 The block SHALL have port ram_data, output, 32, meaning RAM write data.
REQ-017 The block SHALL have port ram_q, input, 32, meaning RAM read data, valid one cycle after the address is presented.

Function
REQ-018 The block SHALL implement states IDLE, RD_WAIT, RMW_WR and RESP, with req_ready=1 only in IDLE.
REQ-019 A request SHALL be accepted in cycle T when req_valid and req_ready are both 1, and all request fields SHALL be captured in T.
REQ-020 In IDLE, ram_address SHALL equal req_addr[31:2]; in all other states it SHALL equal the captured address.
REQ-021 Byte lanes SHALL be little-endian: byte offset 0 maps to bits 7:0, and halfword offset 0 maps to bits 15:0.
REQ-022 A load SHALL go IDLE(T) to RD_WAIT(T+1), sample ram_q at the end of T+1, go to RESP(T+2), and assert resp_valid in T+2.
REQ-023 Load extraction SHALL select the addressed byte or halfword and zero-extend it, or sign-extend it when req_signed=1; a word load SHALL pass ram_q through unchanged.
REQ-024 A word store SHALL assert ram_wren combinationally in T with ram_data=req_wdata, then go to RESP and assert resp_valid in T+1.
REQ-025 A byte or halfword store SHALL read in T, and in T+1 (RMW_WR) assert ram_wren with ram_data equal to ram_q with only the addressed lanes replaced by req_wdata, then go to RESP and assert resp_valid in T+2.
REQ-026 ram_wren SHALL be 0 in all other cycles, and the block SHALL write the RAM at most once per request.
REQ-027 When req_addr[31:2] is greater than or equal to MEM_WORDS, the block SHALL perform no RAM write, SHALL assert resp_valid in T+1 with resp_err=1, and SHALL drive resp_rdata=0.
REQ-028 resp_valid SHALL be high for exactly one cycle per request and SHALL have no backpressure.
REQ-029 The block SHALL return to IDLE after RESP and SHALL be able to accept a new request in the cycle after RESP.
REQ-030 resp_rdata SHALL be 0 for stores and SHALL be held between responses.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, resp_valid=0, resp_err=0, resp_rdata=0, and ram_wren=0.
REQ-032 Reset asserted in any state other than IDLE SHALL abandon the pending request with no RAM write and no response.
REQ-033 The first request SHALL be accepted no earlier than the first rising edge after rst_n deasserts.

Configuration
REQ-034 With MISALIGN_CHECK_EN defined, a halfword access with addr[0]=1, or a word access with addr[1:0] not equal to 0, SHALL be rejected as in REQ-027.
REQ-035 Without MISALIGN_CHECK_EN, for misaligned accesses the offending low address bits SHALL be ignored (forced alignment), and the block SHALL never raise resp_err for alignment.

Verification
REQ-036 Scenario: word store addr 0x40 data 0xDEADBEEF, then word load 0x40 -> ram_wren pulses in the accept cycle at ram_address 0x10, and the load returns resp_rdata 0xDEADBEEF with resp_valid 2 cycles after accept.
REQ-037 Scenario: word 0x11223344 preloaded at 0x40, byte store 0xAA to addr 0x42 -> one write in T+1 with ram_data 0x11AA3344, and resp_valid in T+2.
REQ-038 Scenario: memory word 0x0000F080 at 0x0, signed byte load 0x0 -> 0xFFFFFF80; unsigned halfword load 0x0 -> 0x0000F080.
REQ-039 Scenario: word load addr 0x1000 with MEM_WORDS=1024 -> resp_err=1 and resp_rdata=0 in T+1, and ram_wren is never asserted.
REQ-040 Scenario: word store to 0x42 -> with MISALIGN_CHECK_EN, resp_err=1 and no write; without it, the write goes to ram_address 0x10.
REQ-041 Scenario: rst_n asserted during RMW_WR -> ram_wren drops immediately, no resp_valid is produced, the memory is unchanged, and req_ready=1 after release.
